ace_ccu_snoop_ctrl: RTL
=======================

Name: ace_ccu_snoop_ctrl

Overview:
- Sequencing controller for the shared CCU path.
- Arbitrates shareable read requests from NoSlvPorts ACE masters round-robin.
- For the granted request, broadcasts a snoop (AC) to every other port, collects the CR responses and drains the CD data.
- Issues one decision per transaction: hit (serve from a cache) or miss (forward to memory) to the CCU datapath that drives the axi_mux port.
- Replaces the fixed port-0 connection of the shareable path.

Parameters:
- NoSlvPorts, 2, number of ACE slave ports / snoop ports (>=1).
- AddrWidth, 64, address width of requests and AC.
- CdBeats, 4, expected CD beats per cache line.
- IdxW, max(1,$clog2(NoSlvPorts)), port index width (localparam).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_valid_i  in  NoSlvPorts  shareable AR pending per port
- req_ready_o  out  NoSlvPorts  one-cycle accept pulse
- req_addr_i  in  NoSlvPorts*AddrWidth  ARADDR per port
- req_snoop_i  in  NoSlvPorts*4  ARSNOOP per port
- ac_valid_o  out  NoSlvPorts  snoop request valid per port
- ac_ready_i  in  NoSlvPorts  snoop request ready
- ac_addr_o  out  AddrWidth  snoop address (shared by all ports)
- ac_snoop_o  out  4  AC snoop type
- cr_valid_i  in  NoSlvPorts  snoop response valid
- cr_ready_o  out  NoSlvPorts  snoop response ready
- cr_resp_i  in  NoSlvPorts*5  CRRESP {WasUnique,IsShared,PassDirty,Error,DataTransfer}
- cd_valid_i  in  NoSlvPorts  snoop data valid
- cd_ready_o  out  NoSlvPorts  snoop data ready
- cd_last_i  in  NoSlvPorts  snoop data last
- cd_sel_o  out  IdxW  port whose CD is forwarded to the requester
- dec_valid_o  out  1  decision valid
- dec_ready_i  in  1  decision accepted
- dec_port_o  out  IdxW  requesting port
- dec_hit_o  out  1  1 = data from snoop, 0 = read memory
- dec_shared_o  out  1  OR of IsShared
- dec_pass_dirty_o  out  1  PassDirty of the source port
- proto_err_o  out  1  sticky protocol error

Interface decision (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Reset (sampled at the clock edge, honoured from any state, mid-transaction included):
  - FSM goes to IDLE; round-robin pointer = 0.
  - All masks and proto_err_o cleared.
  - All valid/ready outputs = 0; cd_sel_o = 0; dec_* = 0.
- IDLE:
  - If any req_valid_i is set, grant the first set bit at or after the pointer (wrap-around).
  - req_ready_o[g] = 1 that cycle only; latch addr, mapped snoop type and g.
  - Pointer becomes g+1 mod NoSlvPorts.
  - Target mask = all ports except g.
  - If the mask is empty (NoSlvPorts=1), go to DECIDE with hit=0; otherwise go to SNOOP.
- Snoop type map, all other ARSNOOP values pass through unchanged:
  - ReadOnce 0000 -> 0000.
  - ReadShared 0001 -> 0001.
  - ReadUnique 0111 -> 0111.
  - CleanUnique 1011 -> CleanInvalid 1001.
  - MakeUnique 1100 -> MakeInvalid 1101.
- SNOOP (AC and CR overlap):
  - ac_valid_o[i] = target & ~ac_sent; ac_addr_o / ac_snoop_o stay stable until all AC handshakes complete.
  - ac_sent[i] sets on ac_valid & ac_ready.
  - cr_ready_o[i] = ac_sent[i] & ~cr_got[i]. A CR arriving in the same cycle as its own AC handshake is not accepted.
  - On a CR handshake, latch the response bits.
  - When cr_got == target, go to DECIDE next cycle.
- Decision rules:
  - Data ports = ports with DataTransfer set.
  - Source = lowest-index data port with Error=0.
  - hit = source exists.
  - shared = OR of IsShared over responders.
  - pass_dirty = source PassDirty.
  - cd_sel_o = source, or 0 if there is no source.
- DECIDE:
  - dec_valid_o held with stable dec_* until dec_ready_i.
  - On handshake: go to DATA if the data-port mask is non-zero, else IDLE (a new grant is possible the next cycle).
- DATA:
  - cd_ready_o[i] = data_pending[i]; all pending ports drain in parallel.
  - Non-source data is discarded by the datapath (cd_sel_o selects the forwarded port).
  - A port clears on cd_valid & cd_ready & cd_last.
  - A beat counter runs on the source port. If cd_last_i arrives on a beat other than CdBeats, or no last by beat CdBeats, set proto_err_o. Draining still completes on last.
  - When all pending ports clear, go to IDLE.
- CR or CD valid arriving on a port outside the expected mask is never acknowledged (ready stays 0).
- Latency, uncontended, N=2, all readies high:
  - request -> req_ready: 0 cycles.
  - AC valid: +1 cycle.
  - CR accepted: earliest +2.
  - dec_valid: +1 cycle after the last CR.

Decomposition:
- ace_pkg gains:
  - CRRESP bit-index constants.
  - An ARSNOOP->ACSNOOP mapping function.
  - An FSM state enum (IDLE, SNOOP, DECIDE, DATA).
- One sub-module, ace_rr_arb: round-robin one-hot grant with pointer update on an enable input, reused for future write snooping.

Test Plan:
- N=2, port 0 ReadShared 0x1000; port 1 CR=00000 -> AC on port 1 only, addr 0x1000 snoop 0001; dec_port=0, hit=0, no DATA phase.
- N=2, port 1 ReadUnique; port 0 CR=01101 (IsShared, PassDirty, DataTransfer), 4 CD beats with last on beat 4 -> ac_snoop=0111, dec hit=1, shared=1, pass_dirty=1, cd_sel=0, proto_err=0, returns to IDLE.
- N=4, ports 0-3 request together three times -> grants 0, 1, 2 in order; with port 2 returning CR 00011 (Error + DataTransfer) and port 3 returning 00001 -> source 3, port 2 data drained.
- CD last on beat 3 with CdBeats=4 -> proto_err_o=1, stays 1 until rst_i.
- rst_i asserted in DATA with CD pending -> next cycle all outputs 0 and FSM in IDLE; a later request gets a fresh grant starting from port 0.
- N=1 with CleanUnique request -> no ac_valid, dec hit=0 one cycle after the grant; stalling dec_ready_i for 5 cycles holds dec_* stable.

Source files
------------

// File: rtl/ace_ccu_snoop_ctrl_pkg.sv
// Shared definitions for the CCU snoop sequencing controller.
//   - CRRESP bit positions
//   - ARSNOOP -> ACSNOOP mapping for shareable reads
//   - Controller FSM state type
package ace_ccu_snoop_ctrl_pkg;

   // CRRESP = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
   localparam int unsigned CrDataTransfer = 0;
   localparam int unsigned CrError        = 1;
   localparam int unsigned CrPassDirty    = 2;
   localparam int unsigned CrIsShared     = 3;
   localparam int unsigned CrWasUnique    = 4;
   localparam int unsigned CrWidth        = 5;

   typedef enum logic [1:0] {
      StIdle,
      StSnoop,
      StDecide,
      StData
   } snoop_state_e;

   // Requests that invalidate other copies snoop with the invalidating
   // counterpart; every other ARSNOOP is forwarded unchanged.
   function automatic logic [3:0] map_ar_snoop(input logic [3:0] ar_snoop);
      logic [3:0] ac_snoop;
      case (ar_snoop)
         4'b1011: ac_snoop = 4'b1001; // CleanUnique -> CleanInvalid
         4'b1100: ac_snoop = 4'b1101; // MakeUnique  -> MakeInvalid
         default: ac_snoop = ar_snoop;
      endcase
      return ac_snoop;
   endfunction

endpackage

// File: rtl/ace_rr_arb.sv
// Round-robin arbiter with one-hot grant.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req_i        : request vector
//   en_i         : grant is taken this cycle; pointer moves past the winner
//   gnt_o        : one-hot grant (first request at or after the pointer)
//   gnt_idx_o    : index of the granted request
module ace_rr_arb #(
   parameter int unsigned NoPorts = 2,
   localparam int unsigned IdxW   = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NoPorts-1:0] req_i,
   input  logic               en_i,
   output logic [NoPorts-1:0] gnt_o,
   output logic [IdxW-1:0]    gnt_idx_o
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] idx;
   logic            found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      idx       = '0;
      found     = 1'b0;
      for (int unsigned k = 0; k < NoPorts; k++) begin
         idx = IdxW'((32'(ptr_q) + k) % NoPorts);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
      ptr_d = ptr_q;
      if (en_i && found) begin
         ptr_d = IdxW'((32'(gnt_idx_o) + 1) % NoPorts);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ace_ccu_snoop_ctrl.sv
// Snoop sequencing controller for the shared CCU read path.
// Grants one shareable read at a time (round-robin), snoops every other
// port over AC, gathers CR responses, issues one hit/miss decision to the
// datapath and drains any CD data.
//   req_*  : per-port shareable AR requests (req_ready_o is a 1-cycle pulse)
//   ac_*   : snoop requests; address/type shared by all ports
//   cr_*   : snoop responses
//   cd_*   : snoop data; cd_sel_o names the port forwarded to the requester
//   dec_*  : decision handshake towards the CCU datapath
//   proto_err_o : sticky, set on a CD burst of the wrong length
module ace_ccu_snoop_ctrl
   import ace_ccu_snoop_ctrl_pkg::*;
#(
   parameter int unsigned NoSlvPorts = 2,
   parameter int unsigned AddrWidth  = 64,
   parameter int unsigned CdBeats    = 4,
   localparam int unsigned IdxW      = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NoSlvPorts-1:0]           req_valid_i,
   output logic [NoSlvPorts-1:0]           req_ready_o,
   input  logic [NoSlvPorts*AddrWidth-1:0] req_addr_i,
   input  logic [NoSlvPorts*4-1:0]         req_snoop_i,
   output logic [NoSlvPorts-1:0]           ac_valid_o,
   input  logic [NoSlvPorts-1:0]           ac_ready_i,
   output logic [AddrWidth-1:0]            ac_addr_o,
   output logic [3:0]                      ac_snoop_o,
   input  logic [NoSlvPorts-1:0]           cr_valid_i,
   output logic [NoSlvPorts-1:0]           cr_ready_o,
   input  logic [NoSlvPorts*CrWidth-1:0]   cr_resp_i,
   input  logic [NoSlvPorts-1:0]           cd_valid_i,
   output logic [NoSlvPorts-1:0]           cd_ready_o,
   input  logic [NoSlvPorts-1:0]           cd_last_i,
   output logic [IdxW-1:0]                 cd_sel_o,
   output logic                            dec_valid_o,
   input  logic                            dec_ready_i,
   output logic [IdxW-1:0]                 dec_port_o,
   output logic                            dec_hit_o,
   output logic                            dec_shared_o,
   output logic                            dec_pass_dirty_o,
   output logic                            proto_err_o
);

   localparam int unsigned N = NoSlvPorts;

   snoop_state_e                state_q, state_d;
   logic [AddrWidth-1:0]        addr_q, addr_d;
   logic [3:0]                  snoop_q, snoop_d;
   logic [IdxW-1:0]             port_q, port_d;
   logic [N-1:0]                target_q, target_d;
   logic [N-1:0]                ac_sent_q, ac_sent_d;
   logic [N-1:0]                cr_got_q, cr_got_d;
   logic [N-1:0]                pend_q, pend_d;
   logic [N-1:0][CrWidth-1:0]   resp_q, resp_d;
   logic [15:0]                 beat_q, beat_d;
   logic                        err_q, err_d;

   logic [N-1:0]    gnt;
   logic [IdxW-1:0] gnt_idx;
   logic            arb_en;

   logic [N-1:0]    data_mask;
   logic [N-1:0]    cd_hs;
   logic [IdxW-1:0] src;
   logic            hit, shared, pass_dirty;
   logic            unused_was_unique;

   ace_rr_arb #(
      .NoPorts (N)
   ) i_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_valid_i),
      .en_i      (arb_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   // Only responders are ever non-zero in resp_q (cleared at each grant).
   always_comb begin
      data_mask         = '0;
      shared            = 1'b0;
      hit               = 1'b0;
      src               = '0;
      unused_was_unique = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         data_mask[i]      = resp_q[i][CrDataTransfer];
         shared            = shared | resp_q[i][CrIsShared];
         unused_was_unique = unused_was_unique ^ resp_q[i][CrWasUnique];
         if (!hit && resp_q[i][CrDataTransfer] && !resp_q[i][CrError]) begin
            hit = 1'b1;
            src = IdxW'(i);
         end
      end
      pass_dirty = hit & resp_q[src][CrPassDirty];
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      snoop_d   = snoop_q;
      port_d    = port_q;
      target_d  = target_q;
      ac_sent_d = ac_sent_q;
      cr_got_d  = cr_got_q;
      pend_d    = pend_q;
      resp_d    = resp_q;
      beat_d    = beat_q;
      err_d     = err_q;
      arb_en    = 1'b0;
      cd_hs     = '0;

      req_ready_o      = '0;
      ac_valid_o       = '0;
      cr_ready_o       = '0;
      cd_ready_o       = '0;
      dec_valid_o      = 1'b0;
      ac_addr_o        = addr_q;
      ac_snoop_o       = snoop_q;
      cd_sel_o         = src;
      dec_port_o       = port_q;
      dec_hit_o        = hit;
      dec_shared_o     = shared;
      dec_pass_dirty_o = pass_dirty;
      proto_err_o      = err_q;

      unique case (state_q)
         StIdle: begin
            // No accept pulse while reset is held: the grant would be lost.
            if (|req_valid_i && !rst_i) begin
               req_ready_o = gnt;
               arb_en      = 1'b1;
               addr_d      = req_addr_i[32'(gnt_idx)*AddrWidth +: AddrWidth];
               snoop_d     = map_ar_snoop(req_snoop_i[32'(gnt_idx)*4 +: 4]);
               port_d      = gnt_idx;
               target_d    = ~gnt;
               ac_sent_d   = '0;
               cr_got_d    = '0;
               pend_d      = '0;
               resp_d      = '0;
               beat_d      = '0;
               state_d     = (target_d == '0) ? StDecide : StSnoop;
            end
         end
         StSnoop: begin
            ac_valid_o = target_q & ~ac_sent_q;
            // Registered ac_sent_q: a CR in the same cycle as its AC is refused.
            cr_ready_o = ac_sent_q & ~cr_got_q;
            ac_sent_d  = ac_sent_q | (ac_valid_o & ac_ready_i);
            for (int unsigned i = 0; i < N; i++) begin
               if (cr_valid_i[i] && cr_ready_o[i]) begin
                  resp_d[i] = cr_resp_i[i*CrWidth +: CrWidth];
               end
            end
            cr_got_d = cr_got_q | (cr_valid_i & cr_ready_o);
            if (cr_got_d == target_q) begin
               state_d = StDecide;
            end
         end
         StDecide: begin
            dec_valid_o = 1'b1;
            if (dec_ready_i) begin
               pend_d  = data_mask;
               state_d = (data_mask != '0) ? StData : StIdle;
            end
         end
         StData: begin
            cd_ready_o = pend_q;
            cd_hs      = cd_valid_i & pend_q;
            if (hit && cd_hs[src]) begin
               beat_d = beat_q + 16'd1;
               // Last on the wrong beat, or no last by the expected beat.
               if (cd_last_i[src] ? (32'(beat_d) != CdBeats) : (32'(beat_d) == CdBeats)) begin
                  err_d = 1'b1;
               end
            end
            pend_d = pend_q & ~(cd_hs & cd_last_i);
            if (pend_d == '0) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         snoop_q   <= '0;
         port_q    <= '0;
         target_q  <= '0;
         ac_sent_q <= '0;
         cr_got_q  <= '0;
         pend_q    <= '0;
         resp_q    <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         snoop_q   <= snoop_d;
         port_q    <= port_d;
         target_q  <= target_d;
         ac_sent_q <= ac_sent_d;
         cr_got_q  <= cr_got_d;
         pend_q    <= pend_d;
         resp_q    <= resp_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
      end
   end

endmodule
